// File: rtl/conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// conv_seq_ctrl
// Start/done controlled tap sequencer for the convolution MAC array. A job can
// first load the TAPS kernel weights (KLOAD), then stream num_pix output
// pixels (RUN). Each pass walks a one-hot tap select through all TAPS taps.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   job request, sampled only while idle
//   mode[1:0]  in   [0] reload kernel, [1] stream data (sampled with start)
//   num_pix    in   pixels to stream (sampled with start)
//   stall      in   freezes sequencing during KLOAD/RUN
//   sel        out  one-hot tap select, zero outside KLOAD/RUN
//   k_load     out  kernel register write strobe for tap sel
//   d_load     out  data window write strobe for tap sel
//   acc_clr    out  accumulator clear, with sel[0] in RUN
//   acc_valid  out  one-cycle pulse, accumulator holds a finished pixel
//   busy       out  high whenever not idle
//   done       out  one-cycle pulse on job completion
// -----------------------------------------------------------------------------
module conv_seq_ctrl #(
   parameter int TAPS  = 9,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] num_pix,
   input  logic             stall,
   output logic [TAPS-1:0]  sel,
   output logic             k_load,
   output logic             d_load,
   output logic             acc_clr,
   output logic             acc_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_KLOAD = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [TAPS-1:0]  SEL_FIRST = TAPS'(1);
   localparam logic [TAPS-1:0]  SEL_NONE  = {TAPS{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [TAPS-1:0]  sel_q, sel_d;
   logic [CNT_W-1:0] pix_q, pix_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic             stream_q, stream_d;   // job continues into RUN after KLOAD
   logic             act_q, act_d;         // current tap cycle is a real (non-stalled) one
   logic             k_load_q, k_load_d;
   logic             d_load_q, d_load_d;
   logic             acc_clr_q, acc_clr_d;
   logic             acc_valid_q, acc_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] pix_inc_s;

   // pix_q < num_q whenever it is incremented, so this never overflows
   assign pix_inc_s = pix_q + CNT_ONE;

   // Registered state, counters and outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= SEL_NONE;
         pix_q       <= CNT_ZERO;
         num_q       <= CNT_ZERO;
         stream_q    <= 1'b0;
         act_q       <= 1'b0;
         k_load_q    <= 1'b0;
         d_load_q    <= 1'b0;
         acc_clr_q   <= 1'b0;
         acc_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         pix_q       <= pix_d;
         num_q       <= num_d;
         stream_q    <= stream_d;
         act_q       <= act_d;
         k_load_q    <= k_load_d;
         d_load_q    <= d_load_d;
         acc_clr_q   <= acc_clr_d;
         acc_valid_q <= acc_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state sequencing and next-cycle output values
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      pix_d       = pix_q;
      num_d       = num_q;
      stream_d    = stream_q;
      act_d       = 1'b0;
      acc_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_d    = num_pix;
               stream_d = mode[1] && (num_pix != CNT_ZERO);
               pix_d    = CNT_ZERO;
               if (mode[0]) begin
                  state_d = ST_KLOAD;
                  sel_d   = SEL_FIRST;
                  act_d   = 1'b1;
               end else if ((mode == 2'b10) && (num_pix != CNT_ZERO)) begin
                  state_d = ST_RUN;
                  sel_d   = SEL_FIRST;
                  act_d   = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  sel_d   = SEL_NONE;
               end
            end else begin
               sel_d = SEL_NONE;
            end
         end

         ST_KLOAD: begin
            // stall sampled now marks the coming cycle as a held (strobe-free) one
            act_d = ~stall;
            if (act_q) begin
               if (sel_q[TAPS-1]) begin
                  if (stream_q) begin
                     state_d = ST_RUN;
                     sel_d   = SEL_FIRST;
                  end else begin
                     state_d = ST_DONE;
                     sel_d   = SEL_NONE;
                  end
               end else begin
                  sel_d = {sel_q[TAPS-2:0], 1'b0};
               end
            end else begin
               sel_d = sel_q;
            end
         end

         ST_RUN: begin
            act_d = ~stall;
            if (act_q) begin
               if (sel_q[TAPS-1]) begin
                  pix_d       = pix_inc_s;
                  acc_valid_d = 1'b1;
                  if (pix_inc_s == num_q) begin
                     state_d = ST_DONE;
                     sel_d   = SEL_NONE;
                  end else begin
                     sel_d = SEL_FIRST;
                  end
               end else begin
                  sel_d = {sel_q[TAPS-2:0], 1'b0};
               end
            end else begin
               sel_d = sel_q;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            sel_d   = SEL_NONE;
         end

         default: begin
            state_d = ST_IDLE;
            sel_d   = SEL_NONE;
         end
      endcase

      k_load_d  = (state_d == ST_KLOAD) && act_d;
      d_load_d  = (state_d == ST_RUN) && act_d;
      acc_clr_d = (state_d == ST_RUN) && act_d && sel_d[0];
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
   end

   assign sel       = sel_q;
   assign k_load    = k_load_q;
   assign d_load    = d_load_q;
   assign acc_clr   = acc_clr_q;
   assign acc_valid = acc_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

   localparam int TAPS  = 9;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [CNT_W-1:0] num_pix;
   logic             stall;
   logic [TAPS-1:0]  sel;
   logic             k_load, d_load, acc_clr, acc_valid, busy, done;

   int compared;
   int mismatched;

   // per-cycle log: {sel, k_load, d_load, acc_clr, acc_valid, busy, done}
   logic [14:0] log_v [0:31];

   int               restart_c;
   logic [1:0]       rs_mode;
   logic [CNT_W-1:0] rs_num;
   int               stall_lo, stall_hi;

   conv_seq_ctrl #(.TAPS(TAPS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .num_pix(num_pix),
      .stall(stall), .sel(sel), .k_load(k_load), .d_load(d_load),
      .acc_clr(acc_clr), .acc_valid(acc_valid), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] ev(input int tap, input bit k, input bit d,
                                      input bit clr, input bit av, input bit bz, input bit dn);
      logic [TAPS-1:0] s;
      s = '0;
      if (tap >= 0) s[tap] = 1'b1;
      return {s, k, d, clr, av, bz, dn};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start is driven in cycle 0; stall high at edge c makes cycle c a held cycle
   task automatic run_job(input logic [1:0] m, input logic [CNT_W-1:0] n, input int ncyc);
      log_v[0] = {sel, k_load, d_load, acc_clr, acc_valid, busy, done};
      for (int c = 1; c <= ncyc; c++) begin
         if (c - 1 == restart_c) begin
            start   = 1'b1;
            mode    = rs_mode;
            num_pix = rs_num;
         end else begin
            start   = (c == 1);
            mode    = m;
            num_pix = n;
         end
         stall = (c >= stall_lo) && (c <= stall_hi);
         tick();
         log_v[c] = {sel, k_load, d_load, acc_clr, acc_valid, busy, done};
      end
      start     = 1'b0;
      stall     = 1'b0;
      restart_c = -1;
      stall_lo  = 0;
      stall_hi  = -1;
   endtask

   task automatic test_reset();
      logic [14:0] o;
      rst = 1'b1; start = 1'b0; stall = 1'b0; mode = 2'b00; num_pix = '0;
      #3;
      o = {sel, k_load, d_load, acc_clr, acc_valid, busy, done};
      compared++;
      if (o !== 15'd0) begin
         mismatched++;
         $display("FAIL reset_state: got %b want %b", o, 15'd0);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         compared++;
         if ({sel, busy, done} !== 11'd0) begin
            mismatched++;
            $display("FAIL idle cyc %0d: sel %b busy %b done %b want all 0", c, sel, busy, done);
         end
      end
   endtask

   task automatic test_mode10();
      logic [14:0] e;
      run_job(2'b10, 16'd2, 22);
      for (int c = 1; c <= 22; c++) begin
         e = ev((c <= 18) ? (c - 1) % 9 : -1, 1'b0, c <= 18, (c == 1) || (c == 10),
                (c == 10) || (c == 19), c <= 19, c == 19);
         compared++;
         if (log_v[c] !== e) begin
            mismatched++;
            $display("FAIL mode10 cyc %0d: got %b want %b", c, log_v[c], e);
         end
      end
   endtask

   task automatic test_mode11();
      logic [14:0] e;
      run_job(2'b11, 16'd1, 21);
      for (int c = 1; c <= 21; c++) begin
         e = ev((c <= 9) ? c - 1 : ((c <= 18) ? c - 10 : -1), c <= 9, (c >= 10) && (c <= 18),
                c == 10, c == 19, c <= 19, c == 19);
         compared++;
         if (log_v[c] !== e) begin
            mismatched++;
            $display("FAIL mode11 cyc %0d: got %b want %b", c, log_v[c], e);
         end
      end
   endtask

   task automatic test_stall();
      logic [14:0] e;
      int          tap;
      stall_lo = 4;
      stall_hi = 6;
      run_job(2'b10, 16'd1, 15);
      for (int c = 1; c <= 15; c++) begin
         tap = (c <= 3) ? c - 1 : ((c <= 7) ? 3 : ((c <= 12) ? c - 4 : -1));
         e = ev(tap, 1'b0, (c <= 12) && !((c >= 4) && (c <= 6)), c == 1, c == 13, c <= 13, c == 13);
         compared++;
         if (log_v[c] !== e) begin
            mismatched++;
            $display("FAIL stall cyc %0d: got %b want %b", c, log_v[c], e);
         end
      end
   endtask

   task automatic test_degenerate();
      logic [14:0] e;
      run_job(2'b00, 16'd5, 3);
      for (int c = 1; c <= 3; c++) begin
         e = ev(-1, 1'b0, 1'b0, 1'b0, 1'b0, c == 1, c == 1);
         compared++;
         if (log_v[c] !== e) begin
            mismatched++;
            $display("FAIL mode00 cyc %0d: got %b want %b", c, log_v[c], e);
         end
      end
      run_job(2'b10, 16'd0, 3);
      for (int c = 1; c <= 3; c++) begin
         e = ev(-1, 1'b0, 1'b0, 1'b0, 1'b0, c == 1, c == 1);
         compared++;
         if (log_v[c] !== e) begin
            mismatched++;
            $display("FAIL mode10_zero cyc %0d: got %b want %b", c, log_v[c], e);
         end
      end
      run_job(2'b01, 16'd3, 12);
      for (int c = 1; c <= 12; c++) begin
         e = ev((c <= 9) ? c - 1 : -1, c <= 9, 1'b0, 1'b0, 1'b0, c <= 10, c == 10);
         compared++;
         if (log_v[c] !== e) begin
            mismatched++;
            $display("FAIL mode01 cyc %0d: got %b want %b", c, log_v[c], e);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [14:0] e;
      restart_c = 5;
      rs_mode   = 2'b11;
      rs_num    = 16'd7;
      run_job(2'b10, 16'd1, 14);
      for (int c = 1; c <= 14; c++) begin
         e = ev((c <= 9) ? c - 1 : -1, 1'b0, c <= 9, c == 1, c == 10, c <= 10, c == 10);
         compared++;
         if (log_v[c] !== e) begin
            mismatched++;
            $display("FAIL ignore_start cyc %0d: got %b want %b", c, log_v[c], e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [14:0] e;
      restart_c = 11;
      rs_mode   = 2'b10;
      rs_num    = 16'd1;
      run_job(2'b10, 16'd1, 22);
      for (int c = 1; c <= 22; c++) begin
         if (c <= 11)
            e = ev((c <= 9) ? c - 1 : -1, 1'b0, c <= 9, c == 1, c == 10, c <= 10, c == 10);
         else
            e = ev((c <= 20) ? c - 12 : -1, 1'b0, c <= 20, c == 12, c == 21, c <= 21, c == 21);
         compared++;
         if (log_v[c] !== e) begin
            mismatched++;
            $display("FAIL back_to_back cyc %0d: got %b want %b", c, log_v[c], e);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [14:0] o;
      logic [14:0] e;
      start = 1'b1; mode = 2'b11; num_pix = 16'd2;
      tick();
      start = 1'b0;
      for (int c = 2; c <= 5; c++) tick();
      o = {sel, k_load, d_load, acc_clr, acc_valid, busy, done};
      e = ev(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (o !== e) begin
         mismatched++;
         $display("FAIL abort_pre cyc 5: got %b want %b", o, e);
      end
      #2;
      rst = 1'b1;
      #1;
      o = {sel, k_load, d_load, acc_clr, acc_valid, busy, done};
      compared++;
      if (o !== 15'd0) begin
         mismatched++;
         $display("FAIL abort_async: got %b want %b", o, 15'd0);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         compared++;
         if ({busy, done} !== 2'b00) begin
            mismatched++;
            $display("FAIL abort_no_done cyc %0d: busy %b done %b want 0 0", c, busy, done);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      restart_c  = -1;
      rs_mode    = 2'b00;
      rs_num     = '0;
      stall_lo   = 0;
      stall_hi   = -1;
      test_reset();
      test_mode10();
      test_mode11();
      test_stall();
      test_degenerate();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_mode11();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
